// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
// Fetch FSM encoding, RV32 opcodes used for prediction, PC increment.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DROP  = 2'd3
    } fetch_state_e;

    localparam logic [6:0]  OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0]  OPCODE_BRANCH = 7'b1100011;
    localparam logic [31:0] PC_INC        = 32'd4;

endpackage

// File: rtl/fetch_sequencer_next_pc.sv
// next_pc_predictor: static next-PC prediction from a fetched instruction.
// STATIC_BRANCH_PREDICT_EN adds backward-taken prediction for branches.
module next_pc_predictor
    import fetch_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     inst_i,
    output logic [XLEN-1:0] next_pc_o,
    output logic            pred_taken_o
);

    logic [6:0]      opcode;
    logic [XLEN-1:0] j_imm;

    assign opcode = inst_i[6:0];
    assign j_imm  = {{(XLEN-20){inst_i[31]}}, inst_i[19:12],
                     inst_i[20], inst_i[30:21], 1'b0};

`ifdef STATIC_BRANCH_PREDICT_EN
    logic [XLEN-1:0] b_imm;
    assign b_imm = {{(XLEN-12){inst_i[31]}}, inst_i[7],
                    inst_i[30:25], inst_i[11:8], 1'b0};
`else
    logic unused_bfields;
    assign unused_bfields = ^inst_i[11:7];
`endif

    // JAL always taken; backward branches taken only when enabled
    always_comb begin
        next_pc_o    = pc_i + PC_INC;
        pred_taken_o = 1'b0;
        if (opcode == OPCODE_JAL) begin
            next_pc_o    = pc_i + j_imm;
            pred_taken_o = 1'b1;
        end
`ifdef STATIC_BRANCH_PREDICT_EN
        else if (opcode == OPCODE_BRANCH && inst_i[31]) begin
            next_pc_o    = pc_i + b_imm;
            pred_taken_o = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC, single outstanding I-cache request, IF/ID buffer.
// Optional macro STATIC_BRANCH_PREDICT_EN enables backward-branch prediction.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            icache_req_valid,
    input  logic            icache_req_ready,
    output logic [XLEN-1:0] icache_req_addr,
    input  logic            icache_resp_valid,
    input  logic [31:0]     icache_resp_inst,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic            id_pred_taken
);

    fetch_state_e    state_q;
    logic [XLEN-1:0] pc_q;
    logic            req_valid_q;
    logic            id_valid_q;
    logic [31:0]     id_inst_q;
    logic [XLEN-1:0] id_pc_q;
    logic            id_pred_q;

    logic [XLEN-1:0] pred_pc;
    logic            pred_taken;
    logic            req_fire;

    next_pc_predictor #(.XLEN(XLEN)) u_pred (
        .pc_i         (pc_q),
        .inst_i       (icache_resp_inst),
        .next_pc_o    (pred_pc),
        .pred_taken_o (pred_taken)
    );

    assign req_fire         = req_valid_q & icache_req_ready;
    assign icache_req_valid = req_valid_q;
    assign icache_req_addr  = pc_q;
    assign id_valid         = id_valid_q;
    assign id_inst          = id_inst_q;
    assign id_pc            = id_pc_q;
    assign id_pred_taken    = id_pred_q;

    // Fetch FSM: redirect wins over every normal transition
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RESET_PC;
            req_valid_q <= 1'b0;
            id_valid_q  <= 1'b0;
            id_inst_q   <= '0;
            id_pc_q     <= '0;
            id_pred_q   <= 1'b0;
        end else if (redirect_valid) begin
            pc_q       <= redirect_pc;
            id_valid_q <= 1'b0;
            unique case (state_q)
                ST_FETCH: begin
                    if (req_fire) begin
                        state_q     <= ST_DROP;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (icache_resp_valid) begin
                        state_q     <= ST_FETCH;
                        req_valid_q <= 1'b1;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                ST_HOLD: begin
                    state_q     <= ST_FETCH;
                    req_valid_q <= 1'b1;
                end
                ST_DROP: begin
                    if (icache_resp_valid) begin
                        state_q     <= ST_FETCH;
                        req_valid_q <= 1'b1;
                    end
                end
            endcase
        end else begin
            unique case (state_q)
                ST_FETCH: begin
                    if (req_fire) begin
                        state_q     <= ST_WAIT;
                        req_valid_q <= 1'b0;
                    end else begin
                        req_valid_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (icache_resp_valid) begin
                        state_q    <= ST_HOLD;
                        id_valid_q <= 1'b1;
                        id_inst_q  <= icache_resp_inst;
                        id_pc_q    <= pc_q;
                        id_pred_q  <= pred_taken;
                        pc_q       <= pred_pc;
                    end
                end
                ST_HOLD: begin
                    if (id_ready) begin
                        state_q     <= ST_FETCH;
                        id_valid_q  <= 1'b0;
                        req_valid_q <= 1'b1;
                    end
                end
                ST_DROP: begin
                    if (icache_resp_valid) begin
                        state_q     <= ST_FETCH;
                        req_valid_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    // A response is only legal while a request is outstanding or squashed
    a_resp_legal: assert property (@(posedge clk) disable iff (reset)
        !(icache_resp_valid &&
          (state_q == ST_FETCH || state_q == ST_HOLD)));

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed plus randomized bench for fetch_sequencer.
// Expectations come from an arithmetic model of the next-pc rules.
module tb_fetch_sequencer;

    localparam logic [31:0] RST_PC = 32'h100;
    localparam logic [31:0] I_ADDI = 32'h0010_0093;
    localparam logic [31:0] I_JP20 = 32'h0200_00EF;
    localparam logic [31:0] I_JM8  = 32'hFF9F_F06F;
    localparam logic [31:0] I_JM20 = 32'hFE1F_F06F;
    localparam logic [31:0] I_BM10 = 32'hFE00_08E3;
    localparam logic [31:0] I_BP10 = 32'h0000_0863;
    localparam logic [31:0] I_X    = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [31:0] icache_req_addr;
    logic        icache_resp_valid;
    logic [31:0] icache_resp_inst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_pred_taken;

    int checks;
    int failures;

    logic [31:0] exp_pc;
    logic [31:0] exp_id_inst;
    logic [31:0] exp_id_pc;
    logic        exp_id_pred;

    fetch_sequencer #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .icache_req_valid  (icache_req_valid),
        .icache_req_ready  (icache_req_ready),
        .icache_req_addr   (icache_req_addr),
        .icache_resp_valid (icache_resp_valid),
        .icache_resp_inst  (icache_resp_inst),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .id_valid          (id_valid),
        .id_ready          (id_ready),
        .id_inst           (id_inst),
        .id_pc             (id_pc),
        .id_pred_taken     (id_pred_taken)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: target offset assembled arithmetically from the immediate fields
    function automatic logic [31:0] ref_next(input logic [31:0] pc,
                                             input logic [31:0] inst,
                                             output logic taken);
        int off;
        taken = 1'b0;
        off   = 4;
        if (inst[6:0] == 7'h6F) begin
            off = int'(inst[30:21]) * 2 + int'(inst[20]) * 2048
                + int'(inst[19:12]) * 4096 - (inst[31] ? 1048576 : 0);
            taken = 1'b1;
        end
`ifdef STATIC_BRANCH_PREDICT_EN
        else if (inst[6:0] == 7'h63 && inst[31]) begin
            off = int'(inst[11:8]) * 2 + int'(inst[30:25]) * 32
                + int'(inst[7]) * 2048 - 4096;
            taken = 1'b1;
        end
`endif
        return pc + 32'(off);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for a request, accept it, answer after lat cycles
    task automatic do_fetch(input logic [31:0] inst, input int lat,
                            input int rdy_dly);
        int n;
        logic pt;
        n = 0;
        while (!icache_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", 32'(icache_req_valid), 32'd1);
        chk("req_addr", icache_req_addr, exp_pc);
        for (int i = 0; i < rdy_dly; i++) begin
            step();
            chk("addr_stable", icache_req_addr, exp_pc);
        end
        icache_req_ready = 1'b1;
        step();
        icache_req_ready = 1'b0;
        chk("req_off_wait", 32'(icache_req_valid), 32'd0);
        for (int i = 1; i < lat; i++) begin
            chk("idv_wait", 32'(id_valid), 32'd0);
            step();
        end
        icache_resp_valid = 1'b1;
        icache_resp_inst  = inst;
        step();
        icache_resp_valid = 1'b0;
        exp_id_inst = inst;
        exp_id_pc   = exp_pc;
        exp_pc      = ref_next(exp_pc, inst, pt);
        exp_id_pred = pt;
        chk("id_valid", 32'(id_valid), 32'd1);
        chk("id_inst", id_inst, exp_id_inst);
        chk("id_pc", id_pc, exp_id_pc);
        chk("id_pred", 32'(id_pred_taken), 32'(exp_id_pred));
    endtask

    // Stall decode for hold cycles, then hand the instruction over
    task automatic consume(input int hold);
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_inst", id_inst, exp_id_inst);
            chk("hold_pc", id_pc, exp_id_pc);
            chk("hold_noreq", 32'(icache_req_valid), 32'd0);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        chk("idv_after_hs", 32'(id_valid), 32'd0);
        chk("req_after_hs", 32'(icache_req_valid), 32'd1);
        chk("addr_after_hs", icache_req_addr, exp_pc);
    endtask

    // Redirect while sitting in FETCH with the cache not ready
    task automatic redirect_fetch(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        step();
        redirect_valid = 1'b0;
        exp_pc = tgt;
        chk("redir_req", 32'(icache_req_valid), 32'd1);
        chk("redir_addr", icache_req_addr, tgt);
    endtask

    task automatic accept();
        int n;
        n = 0;
        while (!icache_req_valid && n < 20) begin
            step();
            n++;
        end
        chk("acc_seen", 32'(icache_req_valid), 32'd1);
        icache_req_ready = 1'b1;
        step();
        icache_req_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] inst;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        icache_req_ready = 1'b0;
        icache_resp_valid = 1'b0;
        icache_resp_inst = '0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        id_ready = 1'b0;
        exp_id_inst = '0;
        exp_id_pc = '0;
        exp_id_pred = 1'b0;

        repeat (3) begin
            step();
            chk("rst_req", 32'(icache_req_valid), 32'd0);
        end
        chk("rst_idv", 32'(id_valid), 32'd0);
        chk("rst_inst", id_inst, 32'd0);
        chk("rst_idpc", id_pc, 32'd0);
        chk("rst_pred", 32'(id_pred_taken), 32'd0);
        reset = 1'b0;
        exp_pc = RST_PC;
        step();
        chk("first_req", 32'(icache_req_valid), 32'd1);
        chk("first_addr", icache_req_addr, 32'h100);

        do_fetch(I_ADDI, 1, 0);
        chk("addi_pc", id_pc, 32'h100);
        consume(0);
        chk("seq_addr", icache_req_addr, 32'h104);

        redirect_fetch(32'h200);
        do_fetch(I_JP20, 1, 1);
        chk("jal_pred", 32'(id_pred_taken), 32'd1);
        consume(5);
        chk("jal_tgt", icache_req_addr, 32'h220);

        do_fetch(I_ADDI, 2, 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h10;
        id_ready = 1'b1;
        step();
        redirect_valid = 1'b0;
        id_ready = 1'b0;
        exp_pc = 32'h10;
        chk("hold_redir_idv", 32'(id_valid), 32'd0);
        chk("hold_redir_addr", icache_req_addr, 32'h10);

        do_fetch(I_JM8, 1, 0);
        consume(0);
        chk("jal_m8", icache_req_addr, 32'h8);
        redirect_fetch(32'h10);
        do_fetch(I_JM20, 1, 0);
        consume(0);
        chk("jal_wrap", icache_req_addr, 32'hFFFF_FFF0);

        accept();
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        step();
        redirect_valid = 1'b0;
        chk("drop_noreq", 32'(icache_req_valid), 32'd0);
        step();
        chk("drop_idv", 32'(id_valid), 32'd0);
        icache_resp_valid = 1'b1;
        icache_resp_inst = I_X;
        step();
        icache_resp_valid = 1'b0;
        chk("drop_x_idv", 32'(id_valid), 32'd0);
        chk("drop_req", 32'(icache_req_valid), 32'd1);
        chk("drop_addr", icache_req_addr, 32'h400);

        accept();
        redirect_valid = 1'b1;
        redirect_pc = 32'h400;
        icache_resp_valid = 1'b1;
        icache_resp_inst = I_X;
        step();
        redirect_valid = 1'b0;
        icache_resp_valid = 1'b0;
        chk("same_idv", 32'(id_valid), 32'd0);
        chk("same_req", 32'(icache_req_valid), 32'd1);
        chk("same_addr", icache_req_addr, 32'h400);

        icache_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h500;
        step();
        icache_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("facc_noreq", 32'(icache_req_valid), 32'd0);
        icache_resp_valid = 1'b1;
        icache_resp_inst = I_X;
        step();
        icache_resp_valid = 1'b0;
        chk("facc_idv", 32'(id_valid), 32'd0);
        chk("facc_addr", icache_req_addr, 32'h500);
        exp_pc = 32'h500;

        redirect_fetch(32'h300);
        do_fetch(I_BM10, 1, 0);
        consume(0);
`ifdef STATIC_BRANCH_PREDICT_EN
        chk("beq_back", icache_req_addr, 32'h2F0);
        chk("beq_back_pred", 32'(exp_id_pred), 32'd1);
`else
        chk("beq_back", icache_req_addr, 32'h304);
        chk("beq_back_pred", 32'(exp_id_pred), 32'd0);
`endif
        redirect_fetch(32'h300);
        do_fetch(I_BP10, 1, 0);
        consume(0);
        chk("beq_fwd", icache_req_addr, 32'h304);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 5) == 0)
                redirect_fetch({$urandom_range(0, 32'h3FFF_FFFF), 2'b00});
            inst = $urandom;
            case ($urandom_range(0, 3))
                0: inst[6:0] = 7'h6F;
                1: inst[6:0] = 7'h63;
                default: ;
            endcase
            do_fetch(inst, $urandom_range(1, 3), $urandom_range(0, 2));
            consume($urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller between the I-cache and the IF/ID pipeline register.
- Holds the PC, keeps one I-cache request outstanding at a time, and buffers the returned instruction for decode behind a valid/ready handshake.
- Predicts JAL targets statically (J-type immediate decode) and applies EX-stage redirects (branch mispredict, JALR) with a squash of any in-flight fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset
- XLEN, 32, address/instruction width; only 32 supported

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- icache_req_valid  output  1  fetch request valid
- icache_req_ready  input  1  I-cache accepts request this cycle
- icache_req_addr  output  XLEN  fetch address (word aligned)
- icache_resp_valid  input  1  instruction returned (one-cycle pulse)
- icache_resp_inst  input  32  returned instruction
- redirect_valid  input  1  EX-stage PC redirect (one-cycle pulse)
- redirect_pc  input  XLEN  redirect target
- id_valid  output  1  buffered instruction valid for decode
- id_ready  input  1  decode accepts instruction
- id_inst  output  32  instruction to decode
- id_pc  output  XLEN  PC of id_inst
- id_pred_taken  output  1  instruction was predicted taken (JAL, or branch with feature)

Behaviour:
- Reset (synchronous, active-high): state=FETCH, pc=RESET_PC, id_valid=0, id_inst=0, id_pc=0, id_pred_taken=0, icache_req_valid=0 during the reset cycle. Request asserted the first cycle after reset deasserts.
- States: FETCH, WAIT, HOLD, DROP.
- FETCH:
  - icache_req_valid=1, icache_req_addr=pc.
  - Address is held stable until accepted, except on redirect.
  - When icache_req_ready=1, go to WAIT.
- WAIT:
  - On icache_resp_valid, register inst, pc and pred into the output buffer and compute next pc.
  - id_valid=1 from the next cycle; go to HOLD.
  - Minimum fetch-to-id_valid latency is 2 cycles after request acceptance with a 1-cycle cache.
- Next-pc rule:
  - If opcode=1101111 (JAL): pc + sign-extended J-imm ({inst[31],inst[19:12],inst[20],inst[30:21],0}), pred=1.
  - Otherwise pc+4, pred=0. Addition is modulo 2^XLEN (wraps).
- HOLD:
  - Outputs stable while id_valid=1 and id_ready=0.
  - On id_valid&id_ready: id_valid=0 next cycle, go to FETCH with the new pc.
- DROP:
  - Waits for the response of a squashed request and discards it (no buffer write).
  - Then goes to FETCH with the redirect pc.
- Redirect (highest priority, any state): pc<=redirect_pc and id_valid<=0 next cycle.
  - FETCH, request not accepted this cycle: stay in FETCH, address becomes redirect_pc next cycle.
  - FETCH, icache_req_ready=1 the same cycle: go to DROP.
  - WAIT, no response this cycle: go to DROP.
  - WAIT, response the same cycle: discard the response, go to FETCH.
  - HOLD: the buffered instruction is squashed. A same-cycle id handshake is ignored here (decode is flushed by the same redirect). Go to FETCH.
  - DROP: update pc only, stay in DROP.
- A redirect during reset is ignored.
- icache_resp_valid in FETCH or HOLD is a protocol error; it is ignored and flagged by an assertion in simulation.
- At most one outstanding request, ever.

Optional Feature:
- Macro: STATIC_BRANCH_PREDICT_EN.
- Defined: opcode 1100011 (BRANCH) with a negative B-imm (inst[31]=1) predicts taken, next pc = pc + B-imm ({inst[31],inst[7],inst[30:25],inst[11:8],0}), id_pred_taken=1. Forward branches predict not-taken.
- Undefined: all branches predict not-taken (pc+4, id_pred_taken=0); B-imm logic is absent.

Decomposition:
- Shared package (include file next to the opcode definitions):
  - fetch state encoding (FETCH/WAIT/HOLD/DROP, 2 bits)
  - OPCODE_JAL / OPCODE_BRANCH constants, reused from the existing opcode defines
  - the 32'd4 PC increment constant
- One sub-module: next_pc_predictor.
  - Combinational.
  - Inputs: pc, inst. Outputs: next_pc, pred_taken.
  - Contains the J/B immediate extraction.
  - Unit-testable in isolation.

Test Plan:
- Reset with RESET_PC=32'h100, 1-cycle cache returning ADDI -> first request addr 0x100; id_pc=0x100, id_pred_taken=0; next request 0x104.
- JAL x1,+0x20 at 0x200 -> next request addr 0x220, id_pred_taken=1.
- JAL with negative offset -8 at 0x10 -> wrap check: next request 0x08; JAL -0x20 at 0x10 -> 0xFFFF_FFF0.
- id_ready held 0 for 5 cycles -> id_inst/id_pc stable, no new request issued; handshake -> request issued next cycle.
- redirect_valid to 0x400 while in WAIT, response 3 cycles later with inst X -> X never reaches decode; next request addr 0x400. Repeat with the response in the same cycle as the redirect -> discarded, next request 0x400 with no DROP wait.
- With STATIC_BRANCH_PREDICT_EN: BEQ offset -0x10 at 0x300 -> next request 0x2F0, id_pred_taken=1; BEQ +0x10 -> 0x304, id_pred_taken=0. Without the macro, both -> 0x304, id_pred_taken=0.
